// File: rtl/fwgpio_reg_arbiter.sv
// fwgpio_reg_arbiter: N_REQ-way round-robin arbiter in front of one fwgpio register port.
// Latency: grant is combinational in IDLE, the target request follows one cycle later,
//          and the response is passed through combinationally in the cycle the target returns it.
// Backpressure: t_ready low holds ISSUE with stable fields. i_ready stays low while a
//               transaction is outstanding. A silent target is cut off after TIMEOUT cycles.
//
// Ports:
//   clock, reset      sole clock; synchronous active-high reset
//   i_adr/i_dat_w     per-requester address / write data, requester k in slice k
//   i_we/i_valid      per-requester write enable / request valid
//   i_ready           one-hot accept strobe (IDLE only)
//   i_dat_r           shared response data (zero unless a normal completion)
//   i_rsp_valid       one-hot response strobe to the granted requester
//   i_rsp_err         response is a timeout, qualified by i_rsp_valid
//   t_adr/t_dat_w/t_we latched request fields to the register port
//   t_valid/t_ready   target request handshake
//   t_dat_r/t_rsp_valid target response
module fwgpio_reg_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADR_WIDTH = 4,
  parameter int DAT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  // requester side
  input  logic [N_REQ*ADR_WIDTH-1:0]     i_adr,
  input  logic [N_REQ*DAT_WIDTH-1:0]     i_dat_w,
  input  logic [N_REQ-1:0]               i_we,
  input  logic [N_REQ-1:0]               i_valid,
  output logic [N_REQ-1:0]               i_ready,
  output logic [DAT_WIDTH-1:0]           i_dat_r,
  output logic [N_REQ-1:0]               i_rsp_valid,
  output logic                           i_rsp_err,
  // target side
  output logic [ADR_WIDTH-1:0]           t_adr,
  output logic [DAT_WIDTH-1:0]           t_dat_w,
  output logic                           t_we,
  output logic                           t_valid,
  input  logic                           t_ready,
  input  logic [DAT_WIDTH-1:0]           t_dat_r,
  input  logic                           t_rsp_valid
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter holds (cycles waited - 1); TIMEOUT is at most 255 so 8 bits suffice.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GW-1:0]         r_gnt;
  logic [GW-1:0]         r_last;
  logic [7:0]            r_cnt;
  logic [ADR_WIDTH-1:0]  r_adr;
  logic [DAT_WIDTH-1:0]  r_dat_w;
  logic                  r_we;

  logic                  w_any;
  logic [GW-1:0]         w_pick;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmo;

  // Round-robin search starting one past the last completed grant. The
  // candidate index is wrapped by a single subtraction so N_REQ need not be
  // a power of two.
  always_comb begin
    int c;
    c      = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = int'(r_last) + k;
      if (c >= N_REQ) begin
        c = c - N_REQ;
      end
      if (!w_any && i_valid[c]) begin
        w_any  = 1'b1;
        w_pick = GW'(c);
      end
    end
  end

  // Next state and all handshake outputs. Everything is forced quiet while
  // reset is high so an abandoned transaction never produces a strobe.
  always_comb begin
    w_state_nxt = r_state;
    i_ready     = '0;
    i_rsp_valid = '0;
    i_rsp_err   = 1'b0;
    i_dat_r     = '0;
    t_valid     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;

    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          // t_rsp_valid is deliberately ignored here (late or stray responses).
          if (w_any) begin
            i_ready[w_pick] = 1'b1;
            w_state_nxt     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          t_valid = 1'b1;
          if (t_ready) begin
            w_accept = 1'b1;
            if (t_rsp_valid) begin
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_WAIT_RSP;
            end
          end
        end
        S_WAIT_RSP: begin
          // A real response wins over a timeout landing in the same cycle.
          if (t_rsp_valid) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            w_tmo       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    if (w_done) begin
      i_rsp_valid[r_gnt] = 1'b1;
      i_dat_r            = t_dat_r;
    end
    if (w_tmo) begin
      i_rsp_valid[r_gnt] = 1'b1;
      i_rsp_err          = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= LAST_RST;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_dat_w <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && w_any) begin
        r_gnt   <= w_pick;
        r_adr   <= i_adr[w_pick*ADR_WIDTH +: ADR_WIDTH];
        r_dat_w <= i_dat_w[w_pick*DAT_WIDTH +: DAT_WIDTH];
        r_we    <= i_we[w_pick];
      end

      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_RSP) begin
        r_cnt <= r_cnt + 8'd1;
      end

      // Fairness pointer advances only when a transaction actually finishes.
      if (w_done || w_tmo) begin
        r_last <= r_gnt;
      end
    end
  end

  // Request fields stay at their latched values outside ISSUE as well.
  assign t_adr   = r_adr;
  assign t_dat_w = r_dat_w;
  assign t_we    = r_we;

endmodule

// File: tb/tb_fwgpio_reg_arbiter.sv
module tb_fwgpio_reg_arbiter;

  localparam int N   = 3;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N*AW-1:0]   i_adr = '0;
  logic [N*DW-1:0]   i_dat_w = '0;
  logic [N-1:0]      i_we = '0;
  logic [N-1:0]      i_valid = '0;
  logic [N-1:0]      i_ready;
  logic [DW-1:0]     i_dat_r;
  logic [N-1:0]      i_rsp_valid;
  logic              i_rsp_err;
  logic [AW-1:0]     t_adr;
  logic [DW-1:0]     t_dat_w;
  logic              t_we;
  logic              t_valid;
  logic              t_ready = 1'b0;
  logic [DW-1:0]     t_dat_r = '0;
  logic              t_rsp_valid = 1'b0;

  fwgpio_reg_arbiter #(
    .N_REQ(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clock(clk), .reset(reset),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_we(i_we), .i_valid(i_valid),
    .i_ready(i_ready), .i_dat_r(i_dat_r), .i_rsp_valid(i_rsp_valid), .i_rsp_err(i_rsp_err),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_we(t_we), .t_valid(t_valid),
    .t_ready(t_ready), .t_dat_r(t_dat_r), .t_rsp_valid(t_rsp_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Transaction-level reference: who owns the port (-1 = nobody), whether
  // the target has taken the request, and how many cycles have elapsed since.
  int            m_owner  = -1;
  bit            m_acc    = 1'b0;
  int            m_waited = 0;
  int            m_last   = N - 1;
  logic [AW-1:0] m_adr    = '0;
  logic [DW-1:0] m_dat    = '0;
  logic          m_we     = 1'b0;

  // Snapshot of DUT outputs taken at the last checked negedge.
  logic [N-1:0]  s_ready, s_rv;
  logic          s_err, s_tv, s_twe;
  logic [DW-1:0] s_dr, s_tdat;
  logic [AW-1:0] s_tadr;
  int            glog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: compare outputs mid-cycle against the model, then let
  // the edge happen and advance the model. Inputs are changed by the caller
  // after this returns.
  task automatic step();
    logic [N-1:0]  e_ready, e_rv;
    logic          e_err, e_tv;
    logic [DW-1:0] e_dr;
    int            g;
    bit            done;
    @(negedge clk);
    e_ready = '0; e_rv = '0; e_err = 1'b0; e_tv = 1'b0; e_dr = '0;
    g = -1; done = 1'b0;
    if (!reset) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (g < 0 && i_valid[c]) g = c;
        end
        if (g >= 0) e_ready[g] = 1'b1;
      end else if (!m_acc) begin
        e_tv = 1'b1;
        if (t_ready && t_rsp_valid) begin
          done = 1'b1; e_rv[m_owner] = 1'b1; e_dr = t_dat_r;
        end
      end else if (t_rsp_valid) begin
        done = 1'b1; e_rv[m_owner] = 1'b1; e_dr = t_dat_r;
      end else if (m_waited == TMO) begin
        done = 1'b1; e_rv[m_owner] = 1'b1; e_err = 1'b1;
      end
    end
    s_ready = i_ready; s_rv = i_rsp_valid; s_err = i_rsp_err; s_dr = i_dat_r;
    s_tv = t_valid; s_tadr = t_adr; s_tdat = t_dat_w; s_twe = t_we;
    chk("i_ready", i_ready, e_ready);
    chk("i_rsp_valid", i_rsp_valid, e_rv);
    chk("i_rsp_err", i_rsp_err, e_err);
    chk("i_dat_r", i_dat_r, e_dr);
    chk("t_valid", t_valid, e_tv);
    chk("t_adr", t_adr, m_adr);
    chk("t_dat_w", t_dat_w, m_dat);
    chk("t_we", t_we, m_we);
    for (int k = 0; k < N; k++) if (i_ready[k] === 1'b1 && !reset) glog.push_back(k);
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_acc = 1'b0; m_waited = 0; m_last = N - 1;
      m_adr = '0; m_dat = '0; m_we = 1'b0;
    end else if (m_owner < 0) begin
      if (g >= 0) begin
        m_owner = g; m_acc = 1'b0;
        m_adr = i_adr[g*AW +: AW]; m_dat = i_dat_w[g*DW +: DW]; m_we = i_we[g];
      end
    end else if (done) begin
      m_last = m_owner; m_owner = -1;
    end else if (!m_acc) begin
      if (t_ready) begin m_acc = 1'b1; m_waited = 1; end
    end else begin
      m_waited++;
    end
    #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int n_acc, lat;
    bit seen;

    // reset
    reset = 1'b1;
    repeat (3) step();
    chk("rst_tadr", s_tadr, 0);
    chk("rst_tvalid", s_tv, 0);
    chk("rst_rsp", s_rv, 0);
    reset = 1'b0;

    // single write from requester 0 with same-cycle response
    i_valid = 3'b001; i_adr[0 +: AW] = 4'd4; i_dat_w[0 +: DW] = 32'h0000_00FF; i_we = 3'b001;
    t_ready = 1'b1; t_rsp_valid = 1'b0;
    step();
    chk("wr_ready", s_ready, 3'b001);
    i_valid = '0; t_rsp_valid = 1'b1; t_dat_r = 32'hDEAD_BEEF;
    step();
    chk("wr_tvalid", s_tv, 1);
    chk("wr_tadr", s_tadr, 4);
    chk("wr_tdat", s_tdat, 32'hFF);
    chk("wr_twe", s_twe, 1);
    chk("wr_rsp", s_rv, 3'b001);
    t_rsp_valid = 1'b0;

    // contention from reset: alternate 0,1,0,1
    reset = 1'b1; step(); step(); reset = 1'b0;
    glog.delete();
    i_valid = 3'b011; t_ready = 1'b1; t_rsp_valid = 1'b1;
    repeat (8) step();
    i_valid = '0; t_rsp_valid = 1'b0;
    step();
    chk("cont_count", glog.size(), 4);
    for (int i = 0; i < glog.size() && i < 4; i++) chk("cont_order", glog[i], i % 2);
    for (int i = 1; i < glog.size(); i++) chk("cont_nodup", (glog[i] != glog[i-1]), 1);

    // read by requester 1, response two cycles after accept
    i_valid = 3'b010; i_adr[AW +: AW] = 4'd8; i_we = '0; t_ready = 1'b1; t_rsp_valid = 1'b0;
    step();
    chk("rd_ready", s_ready, 3'b010);
    i_valid = '0;
    step();
    chk("rd_adr", s_tadr, 8);
    step();
    t_rsp_valid = 1'b1; t_dat_r = 32'h1234_5678;
    step();
    chk("rd_rsp", s_rv, 3'b010);
    chk("rd_dat", s_dr, 32'h1234_5678);
    chk("rd_err", s_err, 0);
    t_rsp_valid = 1'b0;

    // backpressure: t_ready low for five cycles
    a = 4'($urandom); d = $urandom;
    i_valid = 3'b001; i_adr[0 +: AW] = a; i_dat_w[0 +: DW] = d; i_we = 3'b001; t_ready = 1'b0;
    step();
    i_valid = '0; i_adr = '1; i_dat_w = '1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_tvalid", s_tv, 1);
      chk("bp_adr", s_tadr, a);
      chk("bp_dat", s_tdat, d);
      if (s_tv && t_ready) n_acc++;
    end
    t_ready = 1'b1; t_rsp_valid = 1'b1;
    step(); if (s_tv && t_ready) n_acc++;
    t_rsp_valid = 1'b0;
    repeat (2) begin step(); if (s_tv && t_ready) n_acc++; end
    chk("bp_accepts", n_acc, 1);

    // timeout from requester 2, then a late response that must be ignored
    i_valid = 3'b100; t_ready = 1'b1; t_rsp_valid = 1'b0; t_dat_r = 32'hCAFE_F00D;
    step();
    i_valid = '0;
    step();
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      if (s_rv != '0) begin seen = 1'b1; lat = c; end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_latency", lat, TMO);
    chk("tmo_who", s_rv, 3'b100);
    chk("tmo_err", s_err, 1);
    chk("tmo_dat", s_dr, 0);
    t_rsp_valid = 1'b1;
    step();
    chk("late_rsp", s_rv, 0);
    t_rsp_valid = 1'b0;

    // reset while waiting: no strobe, requester 0 first afterwards
    i_valid = 3'b010;
    step();
    i_valid = '0;
    repeat (3) step();
    reset = 1'b1; t_rsp_valid = 1'b1;
    step();
    chk("rstw_rsp", s_rv, 0);
    t_rsp_valid = 1'b0;
    step();
    reset = 1'b0; i_valid = 3'b011;
    step();
    chk("rstw_first", s_ready, 3'b001);
    i_valid = '0; t_rsp_valid = 1'b1;
    step();
    t_rsp_valid = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      i_valid     = N'($urandom);
      i_we        = N'($urandom);
      i_adr       = (N*AW)'({$urandom, $urandom});
      i_dat_w     = {$urandom, $urandom, $urandom};
      t_ready     = ($urandom_range(0, 3) != 0);
      t_rsp_valid = ($urandom_range(0, 7) == 0);
      t_dat_r     = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
